// File: rtl/ibex_fetch_fifo.sv
`default_nettype none
// ============================================================================
// Module   : ibex_fetch_fifo
// Brief    : Instruction prefetch queue with configurable depth/outstanding
//            requests, bus-error propagation and halfword realignment.
// Revision : 1.0
// ============================================================================
module ibex_fetch_fifo #(
    parameter int unsigned Depth          = 3,
    parameter int unsigned MaxOutstanding = 2
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        req_i,
    input  logic        branch_i,
    input  logic [31:0] branch_addr_i,
    output logic        instr_req_o,
    output logic [31:0] instr_addr_o,
    input  logic        instr_gnt_i,
    input  logic        instr_rvalid_i,
    input  logic [31:0] instr_rdata_i,
    input  logic        instr_err_i,
    output logic        valid_o,
    input  logic        ready_i,
    output logic [31:0] rdata_o,
    output logic [31:0] addr_o,
    output logic        err_o,
    output logic        busy_o
);

    localparam int unsigned C_PTR_W = (Depth > 1) ? $clog2(Depth) : 1;
    localparam int unsigned C_CNT_W = $clog2(Depth + 1);
    localparam logic [C_CNT_W-1:0] C_DEPTH   = C_CNT_W'(Depth);
    localparam logic [C_CNT_W-1:0] C_MAX_OUT = C_CNT_W'(MaxOutstanding);
    localparam logic [C_PTR_W-1:0] C_LAST    = C_PTR_W'(Depth - 1);

    logic [31:0]        r_mem_data [Depth];
    logic               r_mem_err  [Depth];
    logic [C_PTR_W-1:0] r_rptr;
    logic [C_PTR_W-1:0] r_wptr;
    logic [C_CNT_W-1:0] r_occ;
    logic [C_CNT_W-1:0] r_outst;
    logic [C_CNT_W-1:0] r_discard;
    logic               r_started;
    logic [31:0]        r_fetch_addr;
    logic [31:1]        r_pc;

    logic [C_PTR_W-1:0] w_rptr_nxt;
    logic [C_PTR_W-1:0] w_wptr_nxt;
    logic [31:0]        w_head_data;
    logic [31:0]        w_next_data;
    logic               w_head_err;
    logic               w_next_err;
    logic               w_off;
    logic [31:0]        w_rdata;
    logic               w_compressed;
    logic               w_occ_ge1;
    logic               w_occ_ge2;
    logic               w_valid;
    logic [C_CNT_W-1:0] w_inflight;
    logic [C_CNT_W:0]   w_fill;
    logic               w_req;
    logic               w_gnt;
    logic               w_rvalid;
    logic               w_push;
    logic               w_adv;
    logic               w_pop;
    logic               w_unused;

    assign w_rptr_nxt = (r_rptr == C_LAST) ? '0 : r_rptr + 1'b1;
    assign w_wptr_nxt = (r_wptr == C_LAST) ? '0 : r_wptr + 1'b1;

    assign w_head_data = r_mem_data[r_rptr];
    assign w_head_err  = r_mem_err[r_rptr];
    assign w_next_data = r_mem_data[w_rptr_nxt];
    assign w_next_err  = r_mem_err[w_rptr_nxt];

    // Odd-halfword head: the instruction straddles head and next word.
    assign w_off        = r_pc[1];
    assign w_rdata      = w_off ? {w_next_data[15:0], w_head_data[31:16]} : w_head_data;
    assign w_compressed = (w_rdata[1:0] != 2'b11);

    assign w_occ_ge1 = (r_occ != '0);
    assign w_occ_ge2 = (r_occ >= C_CNT_W'(2));
    assign w_valid   = (w_occ_ge1 & (~w_off | w_compressed | w_head_err)) | w_occ_ge2;

    // Responses still owed to the live stream reserve a FIFO slot each.
    assign w_inflight = r_outst - r_discard;
    assign w_fill     = {1'b0, r_occ} + {1'b0, w_inflight};
    assign w_req      = req_i & (r_started | branch_i) & (r_outst < C_MAX_OUT)
                      & (w_fill < {1'b0, C_DEPTH});
    assign w_gnt      = w_req & instr_gnt_i;

    assign w_rvalid = instr_rvalid_i & (r_outst != '0);
    assign w_push   = w_rvalid & (r_discard == '0) & ~branch_i;
    assign w_adv    = w_valid & ready_i & ~branch_i;
    assign w_pop    = w_adv & (w_off | ~w_compressed);

    assign instr_req_o  = w_req;
    assign instr_addr_o = branch_i ? {branch_addr_i[31:2], 2'b00} : r_fetch_addr;
    assign valid_o      = w_valid;
    assign rdata_o      = w_rdata;
    assign addr_o       = {r_pc, 1'b0};
    assign err_o        = w_head_err | (w_off & ~w_compressed & w_occ_ge2 & w_next_err);
    assign busy_o       = w_req | (r_outst != '0);
    assign w_unused     = branch_addr_i[0];

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_rptr       <= '0;
            r_wptr       <= '0;
            r_occ        <= '0;
            r_outst      <= '0;
            r_discard    <= '0;
            r_started    <= 1'b0;
            r_fetch_addr <= '0;
            r_pc         <= '0;
        end else begin
            if (w_gnt) begin
                r_fetch_addr <= instr_addr_o + 32'd4;
            end else if (branch_i) begin
                r_fetch_addr <= {branch_addr_i[31:2], 2'b00};
            end
            r_outst <= r_outst + C_CNT_W'(w_gnt) - C_CNT_W'(w_rvalid);

            if (branch_i) begin
                r_discard <= r_outst - C_CNT_W'(w_rvalid);
                r_started <= 1'b1;
                r_occ     <= '0;
                r_rptr    <= '0;
                r_wptr    <= '0;
                r_pc      <= branch_addr_i[31:1];
            end else begin
                if (w_rvalid && (r_discard != '0)) begin
                    r_discard <= r_discard - 1'b1;
                end
                r_occ <= r_occ + C_CNT_W'(w_push) - C_CNT_W'(w_pop);
                if (w_push) begin
                    r_wptr <= w_wptr_nxt;
                end
                if (w_pop) begin
                    r_rptr <= w_rptr_nxt;
                end
                if (w_adv) begin
                    r_pc <= r_pc + (w_compressed ? 31'd1 : 31'd2);
                end
            end
        end
    end

    // Storage is cleared on reset so the realigned output is never X.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            for (int unsigned i = 0; i < Depth; i++) begin
                r_mem_data[i] <= '0;
                r_mem_err[i]  <= 1'b0;
            end
        end else if (w_push) begin
            r_mem_data[r_wptr] <= instr_rdata_i;
            r_mem_err[r_wptr]  <= instr_err_i;
        end
    end

    a_no_spurious_rvalid: assert property (@(posedge clk_i) disable iff (!rst_ni)
        !(instr_rvalid_i && (r_outst == '0)));
    a_no_overflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
        (w_fill <= {1'b0, C_DEPTH}));

endmodule
`default_nettype wire
